// File: rtl/sequenciador_muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// ALU select codes and the sequencer state encoding.
package sequenciador_muldiv_pkg;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        DIV_CMP = 3'd2,
        DIV_SUB = 3'd3,
        FIM     = 3'd4
    } estado_t;

endpackage

// File: rtl/sequenciador_muldiv.sv
// Multi-cycle unsigned multiply/divide controller that borrows the
// shared ALU: shift-add multiply and restoring division, 8 steps each.
module sequenciador_muldiv
    import sequenciador_muldiv_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic               operacao,
    input  logic [LARGURA-1:0] operando_a,
    input  logic [LARGURA-1:0] operando_b,
    output logic [LARGURA-1:0] ula_entrada1,
    output logic [LARGURA-1:0] ula_entrada2,
    output logic [2:0]         ula_sinal,
    input  logic [LARGURA-1:0] ula_saida,
    input  logic               ula_zero,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] resultado_hi,
    output logic [LARGURA-1:0] resultado_lo,
    output logic               erro_div0
);

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] acc_q, acc_d;
    logic [LARGURA-1:0] lo_q, lo_d;
    logic [LARGURA-1:0] b_q, b_d;
    logic [2:0]         cont_q, cont_d;
    logic [LARGURA-1:0] hi_q, hi_d;
    logic [LARGURA-1:0] rlo_q, rlo_d;
    logic               erro_q, erro_d;
    logic               pronto_q, pronto_d;

    logic [LARGURA-1:0] s;
    logic               carry;
    logic               ultimo;

    assign s      = {acc_q[LARGURA-2:0], lo_q[LARGURA-1]};
    assign carry  = (ula_saida < acc_q);
    assign ultimo = (cont_q == 3'd7);

    // ALU operand/select drive, purely a function of the current state
    always_comb begin
        ula_entrada1 = '0;
        ula_entrada2 = '0;
        ula_sinal    = ULA_AND;
        case (estado_q)
            MUL: begin
                ula_sinal    = ULA_ADD;
                ula_entrada1 = acc_q;
                ula_entrada2 = lo_q[0] ? b_q : '0;
            end
            DIV_CMP: begin
                ula_sinal    = ULA_SLT;
                ula_entrada1 = s;
                ula_entrada2 = b_q;
            end
            DIV_SUB: begin
                ula_sinal    = ULA_SUB;
                ula_entrada1 = acc_q;
                ula_entrada2 = b_q;
            end
            default: ;
        endcase
    end

    // Next-state and datapath update; results latch on entry to FIM
    always_comb begin
        estado_d = estado_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cont_d   = cont_q;
        hi_d     = hi_q;
        rlo_d    = rlo_q;
        erro_d   = erro_q;
        pronto_d = 1'b0;
        case (estado_q)
            IDLE: begin
                if (inicio) begin
                    b_d    = operando_b;
                    cont_d = 3'd0;
                    erro_d = 1'b0;
                    if (!operacao || (operando_b != '0)) begin
                        acc_d    = '0;
                        lo_d     = operando_a;
                        estado_d = operacao ? DIV_CMP : MUL;
                    end else begin
                        erro_d   = 1'b1;
                        rlo_d    = '1;
                        hi_d     = operando_a;
                        estado_d = FIM;
                        pronto_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d  = {carry, ula_saida[LARGURA-1:1]};
                lo_d   = {ula_saida[0], lo_q[LARGURA-1:1]};
                cont_d = cont_q + 3'd1;
                if (ultimo) begin
                    estado_d = FIM;
                    pronto_d = 1'b1;
                    hi_d     = {carry, ula_saida[LARGURA-1:1]};
                    rlo_d    = {ula_saida[0], lo_q[LARGURA-1:1]};
                end
            end
            DIV_CMP: begin
                acc_d = s;
                lo_d  = {lo_q[LARGURA-2:0], 1'b0};
                // s < b and no lost top bit: quotient bit stays 0
                if (!acc_q[LARGURA-1] && !ula_zero) begin
                    cont_d = cont_q + 3'd1;
                    if (ultimo) begin
                        estado_d = FIM;
                        pronto_d = 1'b1;
                        hi_d     = s;
                        rlo_d    = {lo_q[LARGURA-2:0], 1'b0};
                    end
                end else begin
                    estado_d = DIV_SUB;
                end
            end
            DIV_SUB: begin
                // mod-2^W subtraction is exact even when s overflowed
                acc_d  = ula_saida;
                lo_d   = {lo_q[LARGURA-1:1], 1'b1};
                cont_d = cont_q + 3'd1;
                if (ultimo) begin
                    estado_d = FIM;
                    pronto_d = 1'b1;
                    hi_d     = ula_saida;
                    rlo_d    = {lo_q[LARGURA-1:1], 1'b1};
                end else begin
                    estado_d = DIV_CMP;
                end
            end
            FIM: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cont_q   <= '0;
            hi_q     <= '0;
            rlo_q    <= '0;
            erro_q   <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cont_q   <= cont_d;
            hi_q     <= hi_d;
            rlo_q    <= rlo_d;
            erro_q   <= erro_d;
            pronto_q <= pronto_d;
        end
    end

    assign ocupado      = (estado_q != IDLE);
    assign pronto       = pronto_q;
    assign resultado_hi = hi_q;
    assign resultado_lo = rlo_q;
    assign erro_div0    = erro_q;

endmodule

// File: tb/tb_sequenciador_muldiv.sv
// Testbench for sequenciador_muldiv with a behavioural shared ALU.
// Expected results are queued at start and compared on pronto.
module tb_sequenciador_muldiv;
    import sequenciador_muldiv_pkg::*;

    logic       clock;
    logic       reset;
    logic       inicio;
    logic       operacao;
    logic [7:0] operando_a;
    logic [7:0] operando_b;
    logic [7:0] ula_entrada1;
    logic [7:0] ula_entrada2;
    logic [2:0] ula_sinal;
    logic [7:0] ula_saida;
    logic       ula_zero;
    logic       ocupado;
    logic       pronto;
    logic [7:0] resultado_hi;
    logic [7:0] resultado_lo;
    logic       erro_div0;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       erro;
        int         lat;
        string      nome;
    } esperado_t;

    esperado_t sb[$];
    int checks = 0;
    int errors = 0;

    sequenciador_muldiv #(.LARGURA(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .inicio       (inicio),
        .operacao     (operacao),
        .operando_a   (operando_a),
        .operando_b   (operando_b),
        .ula_entrada1 (ula_entrada1),
        .ula_entrada2 (ula_entrada2),
        .ula_sinal    (ula_sinal),
        .ula_saida    (ula_saida),
        .ula_zero     (ula_zero),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .resultado_hi (resultado_hi),
        .resultado_lo (resultado_lo),
        .erro_div0    (erro_div0)
    );

    // Shared ALU stand-in (slt is an unsigned compare)
    always_comb begin
        ula_saida = 8'h00;
        case (ula_sinal)
            ULA_AND: ula_saida = ula_entrada1 & ula_entrada2;
            ULA_OR:  ula_saida = ula_entrada1 | ula_entrada2;
            ULA_ADD: ula_saida = ula_entrada1 + ula_entrada2;
            ULA_SUB: ula_saida = ula_entrada1 - ula_entrada2;
            ULA_SLT: ula_saida = (ula_entrada1 < ula_entrada2) ? 8'h01 : 8'h00;
            default: ula_saida = 8'h00;
        endcase
    end
    assign ula_zero = (ula_saida == 8'h00);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push_model(input logic op, input logic [7:0] a,
                              input logic [7:0] b, input string nome);
        esperado_t e;
        logic [15:0] p;
        logic [7:0] q;
        e.nome = nome;
        if (!op) begin
            p = 16'(a) * 16'(b);
            e.hi = p[15:8];
            e.lo = p[7:0];
            e.erro = 1'b0;
            e.lat = 9;
        end else if (b == 8'h00) begin
            e.hi = a;
            e.lo = 8'hFF;
            e.erro = 1'b1;
            e.lat = 1;
        end else begin
            q = a / b;
            e.hi = a % b;
            e.lo = q;
            e.erro = 1'b0;
            e.lat = 9 + $countones(q);
        end
        sb.push_back(e);
    endtask

    // Start one operation; optionally pulse inicio in busy cycle 'poke'
    // and/or during FIM, then compare the popped scoreboard entry.
    task automatic run_op(input logic op, input logic [7:0] a,
                          input logic [7:0] b, input string nome,
                          input int poke, input bit fim_poke);
        esperado_t e;
        int n;
        push_model(op, a, b, nome);
        @(negedge clock);
        inicio = 1'b1;
        operacao = op;
        operando_a = a;
        operando_b = b;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (poke == n) begin
                inicio = 1'b1;
                operacao = 1'b0;
                operando_a = 8'h77;
                operando_b = 8'h55;
            end else begin
                inicio = 1'b0;
            end
            if (pronto) break;
        end
        inicio = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!pronto) begin
            errors++;
            $display("FAIL %s timeout: no pronto after %0d cycles", e.nome, n);
        end else begin
            checks++;
            if (n !== e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", e.nome, n, e.lat);
            end
            checks++;
            if (resultado_hi !== e.hi) begin
                errors++;
                $display("FAIL %s hi: got %h expected %h", e.nome, resultado_hi, e.hi);
            end
            checks++;
            if (resultado_lo !== e.lo) begin
                errors++;
                $display("FAIL %s lo: got %h expected %h", e.nome, resultado_lo, e.lo);
            end
            checks++;
            if (erro_div0 !== e.erro) begin
                errors++;
                $display("FAIL %s erro_div0: got %b expected %b", e.nome, erro_div0, e.erro);
            end
            if (fim_poke) begin
                inicio = 1'b1;
                operacao = 1'b1;
                operando_a = 8'h10;
                operando_b = 8'h00;
                @(negedge clock);
                inicio = 1'b0;
                repeat (3) begin
                    checks++;
                    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
                        errors++;
                        $display("FAIL %s fim_ignore: ocupado=%b pronto=%b expected 0 0",
                                 e.nome, ocupado, pronto);
                    end
                    @(negedge clock);
                end
                checks++;
                if (resultado_hi !== e.hi || resultado_lo !== e.lo) begin
                    errors++;
                    $display("FAIL %s hold: got %h %h expected %h %h",
                             e.nome, resultado_hi, resultado_lo, e.hi, e.lo);
                end
            end
        end
    endtask

    task automatic check_idle_zero(input string nome);
        checks++;
        if (ocupado !== 1'b0 || pronto !== 1'b0 || erro_div0 !== 1'b0 ||
            resultado_hi !== 8'h00 || resultado_lo !== 8'h00 ||
            ula_sinal !== 3'b000 || ula_entrada1 !== 8'h00 ||
            ula_entrada2 !== 8'h00) begin
            errors++;
            $display("FAIL %s: ocu=%b pr=%b err=%b hi=%h lo=%h sel=%b e1=%h e2=%h expected all zero",
                     nome, ocupado, pronto, erro_div0, resultado_hi,
                     resultado_lo, ula_sinal, ula_entrada1, ula_entrada2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inicio = 1'b0;
        operacao = 1'b0;
        operando_a = 8'h00;
        operando_b = 8'h00;
        repeat (2) @(negedge clock);
        check_idle_zero("reset_state");
        reset = 1'b0;
        @(negedge clock);
        check_idle_zero("idle_after_reset");
    endtask

    task automatic test_multiply();
        run_op(1'b0, 8'h0D, 8'h0B, "mul_0D_0B", 0, 1'b0);
        run_op(1'b0, 8'hFF, 8'hFF, "mul_FF_FF", 0, 1'b0);
        run_op(1'b0, 8'h00, 8'h5A, "mul_00_5A", 0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   "mul_rand", 0, 1'b0);
    endtask

    task automatic test_divide();
        run_op(1'b1, 8'hC8, 8'h07, "div_C8_07", 0, 1'b0);
        run_op(1'b1, 8'hFF, 8'h01, "div_FF_01", 0, 1'b0);
        run_op(1'b1, 8'h03, 8'h09, "div_03_09", 0, 1'b0);
        run_op(1'b1, 8'hFF, 8'h81, "div_FF_81", 0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_op(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
                   "div_rand", 0, 1'b0);
    endtask

    task automatic test_div_zero();
        run_op(1'b1, 8'h05, 8'h00, "div_05_00", 0, 1'b0);
        run_op(1'b0, 8'h02, 8'h03, "mul_after_div0", 0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_op(1'b0, 8'h0D, 8'h0B, "mul_poke_busy", 4, 1'b0);
        run_op(1'b1, 8'hC8, 8'h07, "div_poke_busy", 6, 1'b0);
        run_op(1'b0, 8'h05, 8'h06, "mul_poke_fim", 0, 1'b1);
    endtask

    task automatic test_reset_mid_div();
        int n;
        @(negedge clock);
        inicio = 1'b1;
        operacao = 1'b1;
        operando_a = 8'hC8;
        operando_b = 8'h07;
        @(negedge clock);
        inicio = 1'b0;
        n = 0;
        while (n < 30 && ula_sinal !== ULA_SUB) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (ula_sinal !== ULA_SUB) begin
            errors++;
            $display("FAIL reach_div_sub: sel=%b expected %b", ula_sinal, ULA_SUB);
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle_zero("reset_mid_div");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle_zero("idle_after_mid_reset");
        run_op(1'b1, 8'h64, 8'h08, "div_64_08", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op(1'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
                   "b2b", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_ignored_start();
        test_reset_mid_div();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
